// File: rtl/decode_regfile_stage_pkg.sv
// Shared constants for the R-type decode / register-read stage:
// instruction field positions, opcode/funct encodings and datapath widths.
package decode_regfile_stage_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int REG_COUNT   = 32;
  localparam int REG_ADDR_W  = $clog2(REG_COUNT);
  localparam int COUNT_WIDTH = 16;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int OP_W      = 6;
  localparam int FUNCT_W   = 6;
  localparam int SHAMT_W   = 5;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;

  localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'h2a;
  localparam logic [FUNCT_W-1:0] FUNCT_SLTU = 6'h2b;
endpackage

// File: rtl/decode_regfile_stage_reg_file_2r1w.sv
// Register file: two combinational read ports, one synchronous write port.
// R0 reads as zero; a same-cycle write is forwarded to matching read ports.
module reg_file_2r1w
  import decode_regfile_stage_pkg::*;
#(
  parameter int DW  = DATA_WIDTH,
  parameter int RC  = REG_COUNT,
  parameter int AW  = $clog2(RC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr_1,
  input  logic [AW-1:0] rd_addr_2,
  output logic [DW-1:0] rd_data_1,
  output logic [DW-1:0] rd_data_2,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);
  logic [DW-1:0] regs [RC];
  logic          wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RC; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Forwarding lets the decode stage latch a value written on the same edge.
  always_comb begin
    rd_data_1 = '0;
    rd_data_2 = '0;
    if (rd_addr_1 != '0) rd_data_1 = (wr_live && wr_addr == rd_addr_1) ? wr_data : regs[rd_addr_1];
    if (rd_addr_2 != '0) rd_data_2 = (wr_live && wr_addr == rd_addr_2) ? wr_data : regs[rd_addr_2];
  end
endmodule

// File: rtl/decode_regfile_stage.sv
// R-type decode and register read: one-entry pipeline register with
// valid/ready handshake feeding the ALU, plus an issued-instruction counter.
module decode_regfile_stage
  import decode_regfile_stage_pkg::*;
#(
  parameter int DW  = DATA_WIDTH,
  parameter int RC  = REG_COUNT,
  parameter int CW  = COUNT_WIDTH,
  parameter int AW  = $clog2(RC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [31:0]          instruction,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [DW-1:0]        wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        read_data_1,
  output logic [DW-1:0]        read_data_2,
  output logic [FUNCT_W-1:0]   function_field,
  output logic [AW-1:0]        out_rd,
  output logic [SHAMT_W-1:0]   out_shamt,
  output logic                 out_illegal,
  output logic [CW-1:0]        issue_count
);
  logic [OP_W-1:0]    op;
  logic [AW-1:0]      rs, rt, rd;
  logic [SHAMT_W-1:0] shamt;
  logic [FUNCT_W-1:0] funct;
  logic [DW-1:0]      rf_data_1, rf_data_2;
  logic               accept;

  assign op    = instruction[OP_LSB    +: OP_W];
  assign rs    = instruction[RS_LSB    +: AW];
  assign rt    = instruction[RT_LSB    +: AW];
  assign rd    = instruction[RD_LSB    +: AW];
  assign shamt = instruction[SHAMT_LSB +: SHAMT_W];
  assign funct = instruction[FUNCT_LSB +: FUNCT_W];

  assign instr_ready = !out_valid || out_ready;
  assign accept      = instr_valid && instr_ready;

  reg_file_2r1w #(.DW(DW), .RC(RC), .AW(AW)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_1 (rs),
    .rd_addr_2 (rt),
    .rd_data_1 (rf_data_1),
    .rd_data_2 (rf_data_2),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data)
  );

  // Data outputs only move on accept, so a stall holds them as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      read_data_1    <= '0;
      read_data_2    <= '0;
      function_field <= '0;
      out_rd         <= '0;
      out_shamt      <= '0;
      out_illegal    <= 1'b0;
      issue_count    <= '0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      read_data_1    <= rf_data_1;
      read_data_2    <= rf_data_2;
      function_field <= funct;
      out_rd         <= rd;
      out_shamt      <= shamt;
      out_illegal    <= (op != OP_RTYPE);
      issue_count    <= issue_count + {{(CW-1){1'b0}}, 1'b1};
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end
endmodule
